// File: rtl/datamem_responder.sv
// Data-memory responder: one load/store at a time into an internal word RAM, RISC-V sizing,
// programmable read latency. Define DMEM_MISALIGN_TRAP_EN to turn misaligned accesses into errors.
module datamem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int         WORDS    = 2 ** (ADDR_W - 2);
    localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              cnt_p0;
    logic [2:0]              cnt_inc;
    logic [DATA_W-1:0]       mem [WORDS];
    logic [DATA_W-1:0]       mem_word;
    logic [DATA_W-1:0]       load_res;
    logic [DATA_W-1:0]       rsp_data_p0;
    logic [ADDR_W-3:0]       word_idx;
    logic [1:0]              lane;
    logic                    accept;
    logic                    is_load;
    logic                    is_store;
    logic                    f3_bad;
    logic                    misalign;
    logic                    req_err;
    logic                    ram_we;

    // Sign/zero extension of the addressed byte or half of a fetched word.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic [2:0]        f3,
                                                      input logic [1:0]        ln);
        logic [7:0]  b;
        logic [15:0] h;
        logic [DATA_W-1:0] res;
        case (ln)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = ln[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Merge right-aligned store data into the lanes selected by size and address.
    function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old,
                                                      input logic [DATA_W-1:0] wd,
                                                      input logic [2:0]        f3,
                                                      input logic [1:0]        ln);
        logic [DATA_W-1:0] res;
        res = old;
        case (f3[1:0])
            2'b00: begin
                case (ln)
                    2'd0:    res[7:0]   = wd[7:0];
                    2'd1:    res[15:8]  = wd[7:0];
                    2'd2:    res[23:16] = wd[7:0];
                    default: res[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (ln[1]) res[31:16] = wd[15:0];
                else       res[15:0]  = wd[15:0];
            end
            default: res = wd;
        endcase
        return res;
    endfunction

    assign word_idx = addr[ADDR_W-1:2];
    assign lane     = addr[1:0];
    assign accept   = (rd | wr) && (state == S_IDLE);
    assign is_load  = rd && !wr;
    assign is_store = wr && !rd;
    assign cnt_inc  = cnt_p0 + 3'd1;

    always_comb begin
        f3_bad = 1'b0;
        if (is_load)
            f3_bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        else if (is_store)
            f3_bad = (funct3 > 3'b010);
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (funct3[1:0])
            2'b01:   misalign = addr[0];
            2'b10:   misalign = |addr[1:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign req_err  = (rd && wr) || f3_bad || misalign;
    assign mem_word = mem[word_idx];
    assign load_res = (is_load && !req_err) ? load_extend(mem_word, funct3, lane) : '0;
    assign ram_we   = accept && is_store && !req_err && !reset;

    // Stage p0: RAM write and captured load result on the acceptance edge.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[word_idx] <= store_merge(mem_word, wr_data, funct3, lane);
        if (accept)
            rsp_data_p0 <= load_res;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = (is_load && !req_err && (RD_LAT > 1)) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (cnt_inc == CNT_LAST)
                    state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p1: response registers, updated only when entering RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt_p0  <= 3'd0;
            rd_data <= '0;
            rsp_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                cnt_p0 <= 3'd0;
                if (accept && (state_nxt == S_RESP)) begin
                    rd_data <= load_res;
                    rsp_err <= req_err;
                end
            end else if (state == S_WAIT) begin
                cnt_p0 <= cnt_inc;
                if (state_nxt == S_RESP) begin
                    rd_data <= rsp_data_p0;
                    rsp_err <= 1'b0;
                end
            end
        end
    end

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

endmodule
